// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the multiplier-to-UART datapath.
// Holds the serializer state encoding and the byte width.
package uart_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } ser_state_t;

    localparam int byte_width_lp = 8;

endpackage

// File: rtl/result_serializer.sv
// Takes one data_width_p-bit result per valid/ready handshake and emits
// it LSB byte first on a byte-wide valid/ready stream toward UART TX.
// Ports: clk_i, reset_ni (async active-low), valid_i/ready_o/data_i
// (word in), valid_o/ready_i/data_o (byte out).
// Optional macro RESULT_SERIALIZER_CHECKSUM_EN appends an XOR checksum
// byte after the data bytes.
module result_serializer
    import uart_alu_pkg::*;
#(
    parameter int data_width_p = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [data_width_p-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [7:0]              data_o
);

    localparam int nbytes_lp = data_width_p / byte_width_lp;
    localparam int idx_raw_lp = $clog2(nbytes_lp + 1);
    localparam int idx_width_lp = (idx_raw_lp < 1) ? 1 : idx_raw_lp;
    localparam logic [idx_width_lp-1:0] last_idx_lp =
        idx_width_lp'(nbytes_lp - 1);

    ser_state_t state, state_nxt;

    logic [data_width_p-1:0] shreg;
    logic [idx_width_lp-1:0] idx;
    logic                    last;

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign last = (idx == last_idx_lp);

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (valid_i) state_nxt = SEND;
            end
            SEND: begin
                if (ready_i && last) begin
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            CSUM: begin
                if (ready_i) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only, so ready_i/valid_i never
    // reach ready_o/valid_o combinationally.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        data_o  = 8'h00;
        unique case (state)
            IDLE: begin
                ready_o = 1'b1;
            end
            SEND: begin
                valid_o = 1'b1;
                data_o  = shreg[7:0];
            end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            CSUM: begin
                valid_o = 1'b1;
                data_o  = csum;
            end
`endif
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

    // Datapath: word capture, byte shift, index and running checksum.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shreg <= '0;
            idx   <= '0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            csum  <= 8'h00;
`endif
        end else if (state == IDLE && valid_i) begin
            shreg <= data_i;
            idx   <= '0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            csum  <= 8'h00;
`endif
        end else if (state == SEND && ready_i) begin
            shreg <= shreg >> byte_width_lp;
            idx   <= idx + idx_width_lp'(1);
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            csum  <= csum ^ shreg[7:0];
`endif
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer at widths 16, 8 and 32.
// Expected byte streams come from a word/byte model with random stalls.
module tb_result_serializer;

    logic        clk;
    logic        rst_n;
    logic        vin;
    logic        rin;
    logic [31:0] din;
    int          sel_r;

    logic       rdy16, vld16, rdy8, vld8, rdy32, vld32;
    logic [7:0] d16, d8, d32;
    logic       rdy, vld;
    logic [7:0] dout;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    result_serializer #(.data_width_p(16)) u16 (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .valid_i (vin && sel_r == 0),
        .ready_o (rdy16),
        .data_i  (din[15:0]),
        .valid_o (vld16),
        .ready_i (rin),
        .data_o  (d16)
    );

    result_serializer #(.data_width_p(8)) u8 (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .valid_i (vin && sel_r == 1),
        .ready_o (rdy8),
        .data_i  (din[7:0]),
        .valid_o (vld8),
        .ready_i (rin),
        .data_o  (d8)
    );

    result_serializer #(.data_width_p(32)) u32 (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .valid_i (vin && sel_r == 2),
        .ready_o (rdy32),
        .data_i  (din),
        .valid_o (vld32),
        .ready_i (rin),
        .data_o  (d32)
    );

    always_comb begin
        rdy  = rdy16;
        vld  = vld16;
        dout = d16;
        case (sel_r)
            1: begin rdy = rdy8;  vld = vld8;  dout = d8;  end
            2: begin rdy = rdy32; vld = vld32; dout = d32; end
            default: ;
        endcase
    end

    task automatic chk(input logic [7:0] obs, input logic [7:0] expv,
                       input string tag);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s sel=%0d observed=%0h expected=%0h",
                   tag, sel_r, obs, expv);
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at the
    // negedge after the last byte, checking the one-cycle idle bubble.
    task automatic frame(input int sel, input logic [31:0] w,
                         input int first_stall, input int stall_max);
        int         nb;
        int         n;
        logic [7:0] b;
        logic [7:0] x;
        logic [7:0] exq[$];
        nb = (sel == 0) ? 2 : (sel == 1) ? 1 : 4;
        x  = 8'h00;
        for (int i = 0; i < nb; i++) begin
            b = w[8*i +: 8];
            exq.push_back(b);
            x = x ^ b;
        end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
        exq.push_back(x);
`endif
        sel_r = sel;
        chk({7'd0, rdy}, 8'd1, "idle_ready");
        chk({7'd0, vld}, 8'd0, "idle_valid");
        din = w;
        vin = 1'b1;
        rin = 1'($urandom_range(0, 1));
        @(negedge clk);
        vin = 1'b0;
        din = $urandom;
        for (int k = 0; k < exq.size(); k++) begin
            n = (k == 0) ? first_stall : $urandom_range(0, stall_max);
            for (int s = 0; s <= n; s++) begin
                chk({7'd0, vld}, 8'd1, "byte_valid");
                chk(dout, exq[k], "byte_data");
                chk({7'd0, rdy}, 8'd0, "busy_ready");
                rin = (s == n);
                vin = 1'($urandom_range(0, 1));
                if (vin) din = 32'hFFFF_FFFF;
                @(negedge clk);
            end
        end
        vin = 1'b0;
        rin = 1'b0;
        chk({7'd0, rdy}, 8'd1, "bubble_ready");
        chk({7'd0, vld}, 8'd0, "bubble_valid");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        vin      = 1'b0;
        rin      = 1'b0;
        din      = '0;
        sel_r    = 0;

        @(negedge clk);
        @(negedge clk);
        chk({7'd0, rdy}, 8'd1, "reset_ready");
        chk({7'd0, vld}, 8'd0, "reset_valid");
        chk(dout, 8'h00, "reset_data");
        rst_n = 1'b1;
        @(negedge clk);

        frame(0, 32'h1234, 0, 0);
        frame(0, 32'hA55A, 3, 0);
        frame(0, 32'h0000_BEEF, 2, 2);
        frame(0, 32'hFFFF, 1, 2);

        // Reset in the middle of a frame.
        sel_r = 0;
        din   = 32'hBEEF;
        vin   = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        chk(dout, 8'hEF, "mid_first");
        rin = 1'b1;
        @(negedge clk);
        chk(dout, 8'hBE, "mid_second");
        rin   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({7'd0, vld}, 8'd0, "mid_rst_valid");
        chk({7'd0, rdy}, 8'd1, "mid_rst_ready");
        chk(dout, 8'h00, "mid_rst_data");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({7'd0, vld}, 8'd0, "post_rst_valid");
        frame(0, 32'h1234, 0, 0);

        for (int i = 0; i < 20; i++) begin
            frame(0, $urandom, $urandom_range(0, 3), 3);
        end

        frame(1, 32'hC3, 0, 0);
        for (int i = 0; i < 6; i++) begin
            frame(1, $urandom, $urandom_range(0, 2), 2);
        end

        frame(2, 32'h0102_0304, 0, 0);
        for (int i = 0; i < 6; i++) begin
            frame(2, $urandom, $urandom_range(0, 2), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
# result_serializer

Downstream stage of the multiplier: accepts one `data_width_p`-bit result per valid/ready handshake and emits it as a stream of bytes, least-significant byte first, on a byte-wide valid/ready interface feeding the UART transmitter. It holds the captured result in a shift register, so the multiplier is released as soon as the word is taken. An optional XOR checksum byte can be appended after the data bytes.

## Interface
- `data_width_p`, 16: result width in bits; must be a multiple of 8 and ≥ 8 (16 = 2×8-bit multiplier).
- `clk_i`  in  1  single clock, rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `valid_i`  in  1  upstream result valid.
- `ready_o`  out  1  serializer can accept a result.
- `data_i`  in  `data_width_p`  result word (multiplier `result_o`).
- `valid_o`  out  1  byte valid toward UART TX.
- `ready_i`  in  1  UART TX accepts byte.
- `data_o`  out  8  current byte.

## Operation
- NBYTES = `data_width_p`/8; byte index counter width = `$clog2(NBYTES+1)`, minimum 1.
- States:
  - IDLE: `ready_o`=1, `valid_o`=0. On `valid_i`, capture `data_i` into the shift register, clear the byte index, clear the checksum, and go to SEND.
  - SEND: `valid_o`=1, `data_o`=shreg[7:0]. On `ready_i`, shift shreg right by 8, XOR the sent byte into the checksum, and increment the index. On the last byte (index = NBYTES-1), go to CSUM if the checksum is enabled, otherwise to IDLE.
  - CSUM: `valid_o`=1, `data_o`=checksum. On `ready_i`, go to IDLE.
- `ready_o` is asserted only in IDLE. No new word is accepted while bytes are pending.
- Backpressure: while `valid_o`=1 and `ready_i`=0, `data_o` and state hold stable. `valid_o` never drops without a handshake.
- `data_i` is sampled only on the IDLE handshake cycle. Later changes to `data_i` have no effect.
- NBYTES=1: SEND lasts one handshake, then IDLE or CSUM.
- Reset asserted mid-frame aborts the frame immediately. On release, the block is in IDLE and no partial bytes resume.

## Timing
- Reset values: `ready_o`=1, `valid_o`=0, `data_o`=8'h00; state=IDLE; shreg, index and checksum are 0.
- Input handshake at edge N: first byte valid at cycle N+1 (one-cycle latency).
- With `ready_i` held high, one byte per cycle. A frame of NBYTES data bytes (+1 with checksum) occupies consecutive cycles.
- Last handshake at edge M: `ready_o`=1 in cycle M+1. This gives exactly one idle bubble between frames; there is no same-cycle accept on the last byte.
- All outputs are registered-state decodes. There is no combinational path from `ready_i` or `valid_i` to `ready_o` or `valid_o`.

## Configuration
- `RESULT_SERIALIZER_CHECKSUM_EN` defined: CSUM state present. After the data bytes, one extra byte equal to the XOR of all data bytes is sent.
- Undefined: CSUM state and checksum register are absent. The frame is exactly NBYTES bytes.

## Structure
- Shared package `uart_alu_pkg`:
  - `ser_state_t` enum {IDLE, SEND, CSUM} (2-bit).
  - `byte_width_lp` = 8.
- No sub-module. The byte index is a plain in-block counter, because the existing `counter` uses a synchronous active-high reset and cannot be shared here.

## Test plan
- Reset mid-frame: `data_i`=16'hBEEF accepted, reset pulsed after the first byte → `valid_o`=0 and `ready_o`=1 during and after reset; the next frame 16'h1234 emits 8'h34, 8'h12 only.
- Basic: `data_i`=16'h1234, `ready_i`=1 → bytes 8'h34 then 8'h12 on consecutive cycles, first one cycle after accept; `ready_o`=1 one cycle after the last byte.
- Backpressure: 16'hA55A with `ready_i` low for 3 cycles while 8'h5A is presented → `data_o` held at 8'h5A, `valid_o` high; then 8'hA5 after release.
- Busy: second `valid_i` with 16'hFFFF during SEND → ignored (`ready_o`=0); accepted only after return to IDLE; both frames emitted intact.
- Checksum: with the macro defined, 16'h1234 → 8'h34, 8'h12, 8'h26; without the macro, only two bytes.
- Width: `data_width_p`=8, `data_i`=8'hC3 → single byte 8'hC3, then IDLE; `data_width_p`=32, 32'h01020304 → 04, 03, 02, 01.
